// File: rtl/fib_mem_sequencer.sv
// Fibonacci memory sequencer: fills memory with F(0)..F(N-1), then serves indexed read-backs.
// Sole initiator on the single-port memory interface.
`timescale 1ns/1ps
module fib_mem_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        count,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  input  logic              rd_req,
  input  logic [3:0]        rd_index,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam int unsigned CntW = 5;

  typedef enum logic [2:0] {StIdle, StGen, StDone, StRdAddr, StRdData} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  // Taint bits mark terms whose true value no longer fits in DATA_W.
  logic              a_tnt_q, b_tnt_q;
  logic [CntW-1:0]   i_q, n_q, n_valid_q;
  logic [3:0]        idx_q;
  logic              ovf_q, rd_valid_q, rd_err_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [CntW-1:0]   n_clamp;
  logic [DATA_W:0]   sum;
  logic              rd_hit;

  assign n_clamp = (count > CntW'(DEPTH)) ? CntW'(DEPTH) : count;
  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign rd_hit  = ({1'b0, idx_q} < n_valid_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic and memory-port / status outputs.
  always_comb begin
    state_d     = state_q;
    mem_wr      = 1'b0;
    mem_address = '0;
    mem_datain  = '0;
    unique case (state_q)
      StIdle: begin
        // start wins over rd_req; a simultaneous read is dropped.
        if (start)       state_d = (n_clamp == '0) ? StDone : StGen;
        else if (rd_req) state_d = StRdAddr;
      end
      StGen: begin
        mem_wr      = 1'b1;
        mem_address = ADDR_W'(i_q);
        mem_datain  = a_q;
        if (i_q + CntW'(1) == n_q) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      StRdAddr: begin
        mem_address = ADDR_W'(idx_q);
        state_d     = StRdData;
      end
      StRdData: begin
        mem_address = ADDR_W'(idx_q);
        state_d     = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Generator datapath, term bookkeeping and read-back capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      a_tnt_q    <= 1'b0;
      b_tnt_q    <= 1'b0;
      i_q        <= '0;
      n_q        <= '0;
      n_valid_q  <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            n_valid_q <= '0;
            ovf_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= DATA_W'(1);
            a_tnt_q   <= 1'b0;
            b_tnt_q   <= 1'b0;
            i_q       <= '0;
            n_q       <= n_clamp;
          end else if (rd_req) begin
            idx_q <= rd_index;
          end
        end
        StGen: begin
          a_q       <= b_q;
          b_q       <= sum[DATA_W-1:0];
          a_tnt_q   <= b_tnt_q;
          b_tnt_q   <= sum[DATA_W] | a_tnt_q | b_tnt_q;
          if (a_tnt_q) ovf_q <= 1'b1;
          i_q       <= i_q + CntW'(1);
          n_valid_q <= i_q + CntW'(1);
        end
        StRdData: begin
          rd_valid_q <= 1'b1;
          rd_err_q   <= ~rd_hit;
          rd_data_q  <= rd_hit ? mem_dataout : '0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign ovf      = ovf_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fib_mem_sequencer.sv
// Scoreboard bench: 32-bit and 8-bit sequencers driven in lockstep, each with a memory model.
`timescale 1ns/1ps
module tb_fib_mem_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] count = '0;
  logic       rd_req = 1'b0;
  logic [3:0] rd_index = '0;

  logic        busy32, done32, ovf32, rdv32, rde32, wr32;
  logic [31:0] rdd32, din32, dout32;
  logic [5:0]  addr32;
  logic        busy8, done8, ovf8, rdv8, rde8, wr8;
  logic [7:0]  rdd8, din8, dout8;
  logic [5:0]  addr8;

  logic [31:0] mem32 [64];
  logic [7:0]  mem8  [64];

  always #5 clk = ~clk;

  fib_mem_sequencer #(.DATA_W(32), .DEPTH(16), .ADDR_W(6)) dut32 (
    .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy32), .done(done32),
    .ovf(ovf32), .rd_req(rd_req), .rd_index(rd_index), .rd_valid(rdv32), .rd_data(rdd32),
    .rd_err(rde32), .mem_address(addr32), .mem_datain(din32), .mem_wr(wr32),
    .mem_dataout(dout32)
  );

  fib_mem_sequencer #(.DATA_W(8), .DEPTH(16), .ADDR_W(6)) dut8 (
    .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy8), .done(done8),
    .ovf(ovf8), .rd_req(rd_req), .rd_index(rd_index), .rd_valid(rdv8), .rd_data(rdd8),
    .rd_err(rde8), .mem_address(addr8), .mem_datain(din8), .mem_wr(wr8),
    .mem_dataout(dout8)
  );

  // Memory models: synchronous write, combinational read.
  always @(posedge clk) begin
    if (wr32) mem32[addr32] <= din32;
    if (wr8)  mem8[addr8]   <= din8;
  end
  assign dout32 = mem32[addr32];
  assign dout8  = mem8[addr8];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; longint d32; longint d8; } wr_t;
  typedef struct { int cyc; int o32; int o8; } dn_t;
  typedef struct { int cyc; longint d32; longint d8; int err; } rd_t;

  wr_t wq[$];
  dn_t dq[$];
  rd_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int nvalid   = 0;  // terms the model believes are valid

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint fib(int n);
    longint x = 0, y = 1, t;
    for (int k = 0; k < n; k++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Monitor: pops expectations whenever either DUT presents an event.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (wr32 || wr8) begin : mon_wr
        wr_t e;
        if (wq.size() == 0) check("unexpected_write", {wr32, wr8}, 0);
        else begin
          e = wq.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_en32", wr32, 1);
          check("wr_en8", wr8, 1);
          check("busy_in_gen", busy32, 1);
          check("wr_addr32", addr32, e.addr);
          check("wr_addr8", addr8, e.addr);
          check("wr_data32", din32, e.d32);
          check("wr_data8", din8, e.d8);
        end
      end
      if (done32 || done8) begin : mon_dn
        dn_t e;
        if (dq.size() == 0) check("unexpected_done", {done32, done8}, 0);
        else begin
          e = dq.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done32", done32, 1);
          check("done8", done8, 1);
          check("ovf32", ovf32, e.o32);
          check("ovf8", ovf8, e.o8);
          check("wr_in_done", wr32, 0);
        end
      end
      if (rdv32 || rdv8) begin : mon_rd
        rd_t e;
        if (rq.size() == 0) check("unexpected_rd_valid", {rdv32, rdv8}, 0);
        else begin
          e = rq.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_valid32", rdv32, 1);
          check("rd_valid8", rdv8, 1);
          check("rd_data32", rdd32, e.d32);
          check("rd_data8", rdd8, e.d8);
          check("rd_err32", rde32, e.err);
          check("rd_err8", rde8, e.err);
        end
      end
    end
  end

  // Wait (bounded) until every expectation has been consumed, then one idle cycle.
  task automatic drain();
    for (int k = 0; k < 80 && (wq.size() + dq.size() + rq.size()) != 0; k++) @(negedge clk);
    if ((wq.size() + dq.size() + rq.size()) != 0) begin
      check("drain_timeout", wq.size() + dq.size() + rq.size(), 0);
      wq.delete();
      dq.delete();
      rq.delete();
    end
    @(negedge clk);
  endtask

  task automatic push_gen(int cnt);
    int n;
    int o32 = 0, o8 = 0;
    n = (cnt > 16) ? 16 : cnt;
    for (int k = 0; k < n; k++) begin
      wq.push_back('{cyc + 1 + k, k, fib(k) & 64'hFFFF_FFFF, fib(k) & 255});
      if (fib(k) > 64'hFFFF_FFFF) o32 = 1;
      if (fib(k) > 255) o8 = 1;
    end
    dq.push_back('{cyc + 1 + n, o32, o8});
    nvalid = n;
  endtask

  task automatic issue_gen(int cnt, bit with_rd, bit poke);
    @(negedge clk);
    start    = 1'b1;
    count    = cnt[4:0];
    rd_req   = with_rd;
    rd_index = 4'($urandom_range(0, 15));
    push_gen(cnt);
    @(negedge clk);
    start  = 1'b0;
    rd_req = 1'b0;
    if (poke) begin
      // Mid-generation start with another count must have no effect.
      repeat (2) @(negedge clk);
      start = 1'b1;
      count = 5'd5;
      @(negedge clk);
      start = 1'b0;
    end
    drain();
  endtask

  task automatic issue_read(int idx);
    bit hit;
    @(negedge clk);
    rd_req   = 1'b1;
    rd_index = idx[3:0];
    hit = (idx < nvalid);
    rq.push_back('{cyc + 3, hit ? (fib(idx) & 64'hFFFF_FFFF) : 0, hit ? (fib(idx) & 255) : 0,
                   hit ? 0 : 1});
    @(negedge clk);
    rd_req = 1'b0;
    drain();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    start = 1'b1;
    count = 5'd12;
    push_gen(12);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);  // write of term 5 is on the port now
    #2 rst = 1'b0;
    #1;
    check("rst_wr32", wr32, 0);
    check("rst_wr8", wr8, 0);
    check("rst_busy32", busy32, 0);
    check("rst_busy8", busy8, 0);
    check("rst_addr32", addr32, 0);
    wq.delete();
    dq.delete();
    nvalid = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", busy32, 0);
    check("reset_done", done32, 0);
    check("reset_ovf", ovf32, 0);
    check("reset_mem_wr", wr32, 0);
    check("reset_mem_address", addr32, 0);
    check("reset_mem_datain", din32, 0);
    check("reset_rd_valid", rdv32, 0);
    check("reset_rd_data", rdd32, 0);
    check("reset_rd_err", rde32, 0);
    check("reset_ovf8", ovf8, 0);
    rst = 1'b1;
    @(negedge clk);

    issue_gen(10, 1'b0, 1'b0);
    issue_read(9);
    issue_read(12);
    issue_gen(0, 1'b0, 1'b0);
    issue_gen(20, 1'b0, 1'b0);
    issue_read(15);
    issue_gen(15, 1'b0, 1'b0);
    issue_read(14);
    issue_gen(14, 1'b0, 1'b0);
    issue_read(13);
    issue_gen(10, 1'b1, 1'b0);
    issue_gen(10, 1'b0, 1'b1);
    mid_reset();
    issue_read(0);

    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 2))
        0:       issue_gen(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b0);
        default: issue_read(int'($urandom_range(0, 15)));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
